// File: rtl/pkt_shift_buf_if.sv
// Packet/word bus for pkt_shift_buf: packet input side, word output side and status flags.
// master = packet producer / word consumer, slave = the shift buffer itself.
interface pkt_shift_buf_if #(
  parameter int PKT_W = 64,
  parameter int OUT_W = 8
);
  logic [PKT_W-1:0] din;
  logic             pkt_rec;
  logic             en;
  logic             SPI_en;
  logic [OUT_W-1:0] dout;
  logic             busy;
  logic             pend;
  logic             done;
  logic             ovf;

  modport master (
    output din, pkt_rec, en, SPI_en,
    input  dout, busy, pend, done, ovf
  );

  modport slave (
    input  din, pkt_rec, en, SPI_en,
    output dout, busy, pend, done, ovf
  );
endinterface

// File: rtl/pkt_shift_buf.sv
// Packet-to-word serializer: an active shift register streams OUT_W-bit words while a
// one-deep shadow register queues the next packet so back-to-back packets have no gap.
module pkt_shift_buf #(
  parameter int PKT_W     = 64,
  parameter int OUT_W     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  pkt_shift_buf_if.slave   bus
);

  localparam int N     = PKT_W / OUT_W;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state;
  logic [PKT_W-1:0] r_active;
  logic [PKT_W-1:0] r_shadow;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pend;
  logic             r_done;
  logic             r_ovf;

  logic             w_busy;
  logic             w_adv;
  logic             w_last;
  logic [PKT_W-1:0] w_shifted;
  logic [OUT_W-1:0] w_word;

  assign w_busy = (r_state == SHIFT);
  assign w_adv  = bus.en & bus.SPI_en & w_busy;
  assign w_last = w_adv && (r_cnt == CNT_W'(1));

  // Output word sits at the end the register shifts toward; vacated bits fill with zero.
  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign w_shifted = r_active << OUT_W;
      assign w_word    = r_active[PKT_W-1 -: OUT_W];
    end else begin : g_lsb
      assign w_shifted = r_active >> OUT_W;
      assign w_word    = r_active[OUT_W-1:0];
    end
  endgenerate

  assign bus.dout = (bus.SPI_en && w_busy) ? w_word : '0;
  assign bus.busy = w_busy;
  assign bus.pend = r_pend;
  assign bus.done = r_done;
  assign bus.ovf  = r_ovf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_active <= '0;
      r_shadow <= '0;
      r_cnt    <= '0;
      r_pend   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= w_last;
      case (r_state)
        IDLE: begin
          if (bus.pkt_rec) begin
            r_active <= bus.din;
            r_cnt    <= N_CNT;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_last) begin
            // Last word leaves: refill from shadow first, else straight from din, else go idle.
            if (r_pend) begin
              r_active <= r_shadow;
              r_cnt    <= N_CNT;
              if (bus.pkt_rec) r_shadow <= bus.din;
              else             r_pend   <= 1'b0;
            end else if (bus.pkt_rec) begin
              r_active <= bus.din;
              r_cnt    <= N_CNT;
            end else begin
              r_active <= w_shifted;
              r_cnt    <= '0;
              r_state  <= IDLE;
            end
          end else begin
            if (w_adv) begin
              r_active <= w_shifted;
              r_cnt    <= r_cnt - CNT_W'(1);
            end
            if (bus.pkt_rec) begin
              r_shadow <= bus.din;
              r_pend   <= 1'b1;
              if (r_pend) r_ovf <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_shift_buf.sv
// Directed bench for pkt_shift_buf: one MSB-first and one LSB-first instance on a shared
// clock and reset, each scenario task checking hand-computed words and flags.
module tb_pkt_shift_buf;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  localparam logic [63:0] PKT_A = 64'hABACABADABAEABAF;
  localparam logic [63:0] PKT_B = 64'h0102030405060708;
  localparam logic [63:0] PKT_C = 64'h1122334455667788;

  logic [7:0] wa [8];
  logic [7:0] wb [8];

  pkt_shift_buf_if #(.PKT_W(64), .OUT_W(8)) bm ();
  pkt_shift_buf_if #(.PKT_W(64), .OUT_W(8)) bl ();

  pkt_shift_buf #(.PKT_W(64), .OUT_W(8), .MSB_FIRST(1)) dut_msb (
    .clk (clk),
    .rst (rst),
    .bus (bm)
  );

  pkt_shift_buf #(.PKT_W(64), .OUT_W(8), .MSB_FIRST(0)) dut_lsb (
    .clk (clk),
    .rst (rst),
    .bus (bl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic load_m(input logic [63:0] d);
    bm.din     = d;
    bm.pkt_rec = 1'b1;
    tick();
    bm.pkt_rec = 1'b0;
  endtask

  task automatic advance_m();
    bm.en = 1'b1;
    tick();
    bm.en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    checks++;
    if (bm.dout !== 8'h00 || bm.busy !== 1'b0 || bm.pend !== 1'b0 || bm.done !== 1'b0 || bm.ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: got dout=%h busy=%b pend=%b done=%b ovf=%b expected all zero",
               bm.dout, bm.busy, bm.pend, bm.done, bm.ovf);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_msb_stream();
    do_reset();
    bm.SPI_en = 1'b1;
    load_m(PKT_A);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bm.dout !== wa[i]) begin
        errors++;
        $display("[TB] FAIL msb_word[%0d]: got %h expected %h", i, bm.dout, wa[i]);
      end
      advance_m();
      checks++;
      if (bm.done !== (i == 7)) begin
        errors++;
        $display("[TB] FAIL msb_done[%0d]: got %b expected %b", i, bm.done, (i == 7));
      end
    end
    checks++;
    if (bm.busy !== 1'b0 || bm.dout !== 8'h00) begin
      errors++;
      $display("[TB] FAIL msb_idle_after: got busy=%b dout=%h expected busy=0 dout=00", bm.busy, bm.dout);
    end
    tick();
    checks++;
    if (bm.done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL msb_done_pulse_width: got %b expected 0", bm.done);
    end
  endtask

  task automatic test_lsb_stream();
    do_reset();
    bl.SPI_en  = 1'b1;
    bl.din     = PKT_A;
    bl.pkt_rec = 1'b1;
    tick();
    bl.pkt_rec = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bl.dout !== wa[7-i]) begin
        errors++;
        $display("[TB] FAIL lsb_word[%0d]: got %h expected %h", i, bl.dout, wa[7-i]);
      end
      bl.en = 1'b1;
      tick();
      bl.en = 1'b0;
    end
    checks++;
    if (bl.done !== 1'b1 || bl.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lsb_end: got done=%b busy=%b expected done=1 busy=0", bl.done, bl.busy);
    end
    bl.SPI_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    bm.SPI_en = 1'b1;
    load_m(PKT_A);
    advance_m();
    advance_m();
    load_m(PKT_B);
    checks++;
    if (bm.pend !== 1'b1 || bm.dout !== wa[2]) begin
      errors++;
      $display("[TB] FAIL b2b_queued: got pend=%b dout=%h expected pend=1 dout=%h", bm.pend, bm.dout, wa[2]);
    end
    repeat (6) advance_m();
    checks++;
    if (bm.dout !== 8'h01 || bm.busy !== 1'b1 || bm.ovf !== 1'b0 || bm.pend !== 1'b0 || bm.done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_switch: got dout=%h busy=%b ovf=%b pend=%b done=%b expected 01 1 0 0 1",
               bm.dout, bm.busy, bm.ovf, bm.pend, bm.done);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bm.dout !== wb[i]) begin
        errors++;
        $display("[TB] FAIL b2b_word[%0d]: got %h expected %h", i, bm.dout, wb[i]);
      end
      advance_m();
    end
    checks++;
    if (bm.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_drained: got busy=%b expected 0", bm.busy);
    end
  endtask

  task automatic test_last_word_collision();
    do_reset();
    bm.SPI_en = 1'b1;
    load_m(PKT_A);
    repeat (7) advance_m();
    // Last-word advance and a new packet in the same cycle with nothing queued.
    bm.din     = PKT_C;
    bm.pkt_rec = 1'b1;
    bm.en      = 1'b1;
    tick();
    bm.pkt_rec = 1'b0;
    bm.en      = 1'b0;
    checks++;
    if (bm.dout !== 8'h11 || bm.done !== 1'b1 || bm.pend !== 1'b0 || bm.ovf !== 1'b0 || bm.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL collide_empty: got dout=%h done=%b pend=%b ovf=%b busy=%b expected 11 1 0 0 1",
               bm.dout, bm.done, bm.pend, bm.ovf, bm.busy);
    end
    load_m(PKT_B);
    repeat (7) advance_m();
    // Same collision with the shadow already full.
    bm.din     = PKT_A;
    bm.pkt_rec = 1'b1;
    bm.en      = 1'b1;
    tick();
    bm.pkt_rec = 1'b0;
    bm.en      = 1'b0;
    checks++;
    if (bm.dout !== 8'h01 || bm.done !== 1'b1 || bm.pend !== 1'b1 || bm.ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL collide_full: got dout=%h done=%b pend=%b ovf=%b expected 01 1 1 0",
               bm.dout, bm.done, bm.pend, bm.ovf);
    end
    repeat (8) advance_m();
    checks++;
    if (bm.dout !== 8'hAB || bm.pend !== 1'b0 || bm.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL collide_shadow_kept: got dout=%h pend=%b busy=%b expected AB 0 1",
               bm.dout, bm.pend, bm.busy);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    bm.SPI_en = 1'b1;
    load_m(PKT_A);
    load_m(PKT_B);
    load_m(PKT_C);
    checks++;
    if (bm.ovf !== 1'b1 || bm.pend !== 1'b1 || bm.dout !== 8'hAB) begin
      errors++;
      $display("[TB] FAIL ovf_set: got ovf=%b pend=%b dout=%h expected 1 1 AB", bm.ovf, bm.pend, bm.dout);
    end
    repeat (8) advance_m();
    checks++;
    if (bm.dout !== 8'h11 || bm.pend !== 1'b0 || bm.ovf !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_shadow_third: got dout=%h pend=%b ovf=%b expected 11 0 1", bm.dout, bm.pend, bm.ovf);
    end
  endtask

  task automatic test_spi_gate();
    do_reset();
    bm.SPI_en = 1'b1;
    load_m(PKT_A);
    advance_m();
    advance_m();
    bm.SPI_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      advance_m();
      checks++;
      if (bm.dout !== 8'h00 || bm.busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL gate_hold[%0d]: got dout=%h busy=%b expected 00 1", i, bm.dout, bm.busy);
      end
    end
    bm.SPI_en = 1'b1;
    #1;
    checks++;
    if (bm.dout !== wa[2]) begin
      errors++;
      $display("[TB] FAIL gate_resume: got %h expected %h", bm.dout, wa[2]);
    end
    advance_m();
    checks++;
    if (bm.dout !== wa[3]) begin
      errors++;
      $display("[TB] FAIL gate_next: got %h expected %h", bm.dout, wa[3]);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bm.SPI_en = 1'b1;
    load_m(PKT_A);
    load_m(PKT_B);
    load_m(PKT_C);
    repeat (3) advance_m();
    checks++;
    if (bm.dout !== wa[3] || bm.pend !== 1'b1 || bm.ovf !== 1'b1) begin
      errors++;
      $display("[TB] FAIL arst_pre: got dout=%h pend=%b ovf=%b expected %h 1 1", bm.dout, bm.pend, bm.ovf, wa[3]);
    end
    rst = 1'b0;
    #2;
    checks++;
    if (bm.dout !== 8'h00 || bm.busy !== 1'b0 || bm.pend !== 1'b0 || bm.ovf !== 1'b0 || bm.done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL arst_clear: got dout=%h busy=%b pend=%b ovf=%b done=%b expected all zero",
               bm.dout, bm.busy, bm.pend, bm.ovf, bm.done);
    end
    rst = 1'b1;
    load_m(PKT_B);
    checks++;
    if (bm.dout !== 8'h01 || bm.busy !== 1'b1 || bm.pend !== 1'b0) begin
      errors++;
      $display("[TB] FAIL arst_reload: got dout=%h busy=%b pend=%b expected 01 1 0", bm.dout, bm.busy, bm.pend);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    wa = '{8'hAB, 8'hAC, 8'hAB, 8'hAD, 8'hAB, 8'hAE, 8'hAB, 8'hAF};
    wb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    rst        = 1'b1;
    bm.din     = '0;
    bm.pkt_rec = 1'b0;
    bm.en      = 1'b0;
    bm.SPI_en  = 1'b0;
    bl.din     = '0;
    bl.pkt_rec = 1'b0;
    bl.en      = 1'b0;
    bl.SPI_en  = 1'b0;
    tick();
    test_reset();
    test_msb_stream();
    test_lsb_stream();
    test_back_to_back();
    test_last_word_collision();
    test_overrun();
    test_spi_gate();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pkt_shift_buf.md
PKT_SHIFT_BUF -- requirements
Module: pkt_shift_buf

Interface
REQ-001 SHALL provide parameter PKT_W, default 64, packet width in bits.
REQ-002 SHALL provide parameter OUT_W, default 8, output word width; PKT_W SHALL be an integer multiple of OUT_W; N = PKT_W/OUT_W.
REQ-003 SHALL provide parameter MSB_FIRST, default 1, word order: 1 = most-significant word first, 0 = least-significant first.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port din, input, PKT_W, packet data, sampled when pkt_rec=1.
REQ-007 SHALL have port pkt_rec, input, 1, packet-received strobe; high for one cycle per packet.
REQ-008 SHALL have port en, input, 1, advance strobe; consumes one word.
REQ-009 SHALL have port SPI_en, input, 1, output enable and advance qualifier.
REQ-010 SHALL have port dout, output, OUT_W, current output word.
REQ-011 SHALL have port busy, output, 1, active register holds unsent words.
REQ-012 SHALL have port pend, output, 1, shadow register holds a queued packet.
REQ-013 SHALL have port done, output, 1, one-cycle pulse on consumption of the last word of a packet.
REQ-014 SHALL have port ovf, output, 1, sticky overrun flag.

Function
REQ-015 SHALL contain an active shift register (PKT_W), a shadow register (PKT_W), a word counter cnt (width clog2(N+1)), and a two-state FSM: IDLE (cnt=0) and SHIFT (cnt>0).
REQ-016 busy SHALL equal 1 exactly when the FSM is in SHIFT.
REQ-017 An advance SHALL occur in a cycle only when en=1, SPI_en=1 and busy=1; en under any other condition SHALL be ignored.
REQ-018 dout SHALL be the upper OUT_W bits of the active register when MSB_FIRST=1, or the lower OUT_W bits when MSB_FIRST=0, and SHALL be driven only while SPI_en=1 and busy=1; otherwise dout SHALL be 0.
REQ-019 On an advance, the active register SHALL shift by OUT_W toward the output end, zero-filling the vacated bits, and cnt SHALL decrement by 1.
REQ-020 pkt_rec in IDLE SHALL load din into the active register and set cnt=N; first word valid on dout the next cycle (1-cycle latency).
REQ-021 pkt_rec in SHIFT with pend=0 SHALL load din into the shadow register and set pend=1.
REQ-022 pkt_rec in SHIFT with pend=1 SHALL overwrite the shadow register and set ovf=1.
REQ-023 An advance with cnt=1 SHALL pulse done for one cycle at the next edge.
REQ-024 Same advance with pend=1 SHALL move shadow to active, set cnt=N, clear pend; FSM stays SHIFT with no idle cycle.
REQ-025 Same advance with pend=0 and pkt_rec=0 SHALL return the FSM to IDLE.
REQ-026 Simultaneous last-word advance and pkt_rec with pend=0: din SHALL load directly into active, cnt=N, done pulses, no ovf.
REQ-027 Simultaneous last-word advance and pkt_rec with pend=1: shadow SHALL move to active, din SHALL load into shadow, pend stays 1, no ovf.
REQ-028 Simultaneous non-last advance and pkt_rec SHALL apply both REQ-019 and REQ-021/022 in the same cycle.
REQ-029 ovf SHALL remain 1 until reset; ovf SHALL have no other effect on operation.

Reset
REQ-030 rst=0 SHALL asynchronously clear active, shadow, cnt, pend, done and ovf, force IDLE, and drive dout=0 and busy=0, including mid-packet.
REQ-031 After rst returns to 1, the first pkt_rec SHALL be handled as in REQ-020.

Verification
REQ-032 Defaults; rst pulse; pkt_rec with din=64'hABACABADABAEABAF; SPI_en=1; 8 en pulses -> dout sequence AB,AC,AB,AD,AB,AE,AB,AF; done on the 8th; busy=0 after.
REQ-033 MSB_FIRST=0, same stimulus -> dout sequence AF,AB,AE,AB,AD,AB,AC,AB.
REQ-034 Load packet A, second pkt_rec B after 2 advances -> pend=1; after the 8th advance, dout=B's first word the next cycle; busy stays 1; ovf=0.
REQ-035 Three pkt_rec before any advance -> ovf=1, pend=1; shadow holds the third packet.
REQ-036 en pulses with SPI_en=0 -> cnt unchanged and dout=0; set SPI_en=1 -> sequence resumes from the same word.
REQ-037 rst=0 after 3 advances -> dout=0, busy=0, pend=0, ovf=0 immediately, without waiting for a clock edge.
